// File: rtl/consmax_ocollect.sv
// Output collector for consmax heads: per-head lane-masked FIFOs drained
// through a round-robin arbiter into a single registered valid/ready output.
module consmax_ocollect #(
  parameter int unsigned NUM_HEAD   = 8,
  parameter int unsigned GBUS_DATA  = 32,
  parameter int unsigned GBUS_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [GBUS_DATA*NUM_HEAD-1:0]   idata,
  input  logic [GBUS_WIDTH*NUM_HEAD-1:0]  idata_valid,
  input  logic                            ovf_clr,
  output logic [GBUS_DATA-1:0]            odata,
  output logic [GBUS_WIDTH-1:0]           omask,
  output logic [$clog2(NUM_HEAD)-1:0]     ohead,
  output logic                            ovalid,
  input  logic                            oready,
  output logic [NUM_HEAD-1:0]             ovf
);

  localparam int unsigned HW     = $clog2(NUM_HEAD);
  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned LANE_W = GBUS_DATA / GBUS_WIDTH;

  typedef struct packed {
    logic [GBUS_DATA-1:0]  data;
    logic [GBUS_WIDTH-1:0] mask;
  } entry_t;

  entry_t        mem   [NUM_HEAD][FIFO_DEPTH];
  logic [PW-1:0] wptr  [NUM_HEAD];
  logic [PW-1:0] rptr  [NUM_HEAD];
  logic [CW-1:0] count [NUM_HEAD];
  logic [HW-1:0] rr_ptr;

  logic [NUM_HEAD-1:0] req_valid;
  logic [NUM_HEAD-1:0] full;
  logic [NUM_HEAD-1:0] nonempty;
  logic [NUM_HEAD-1:0] push;
  logic [NUM_HEAD-1:0] pop;
  entry_t              push_entry [NUM_HEAD];
  logic [HW-1:0]       grant;
  logic                load;

  // Per-head push decode; invalid lanes are zeroed before storage.
  always_comb begin
    for (int unsigned h = 0; h < NUM_HEAD; h++) begin
      push_entry[h] = '0;
      req_valid[h]  = |idata_valid[h*GBUS_WIDTH +: GBUS_WIDTH];
      full[h]       = (count[h] == CW'(FIFO_DEPTH));
      nonempty[h]   = (count[h] != '0);
      push[h]       = req_valid[h] && !full[h];
      push_entry[h].mask = idata_valid[h*GBUS_WIDTH +: GBUS_WIDTH];
      for (int unsigned l = 0; l < GBUS_WIDTH; l++) begin
        push_entry[h].data[l*LANE_W +: LANE_W] =
          idata[h*GBUS_DATA + l*LANE_W +: LANE_W] & {LANE_W{idata_valid[h*GBUS_WIDTH + l]}};
      end
    end
  end

  // Round-robin search starting at rr_ptr, using pre-push occupancy.
  always_comb begin : arb
    int unsigned   idx;
    logic [HW-1:0] hidx;
    logic          found;
    idx   = 0;
    hidx  = '0;
    found = 1'b0;
    grant = '0;
    pop   = '0;
    for (int unsigned k = 0; k < NUM_HEAD; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_HEAD) idx = idx - NUM_HEAD;
      hidx = HW'(idx);
      if (!found && nonempty[hidx]) begin
        found = 1'b1;
        grant = hidx;
      end
    end
    load = found && (!ovalid || oready);
    if (load) pop[grant] = 1'b1;
  end

  // FIFO storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    for (int unsigned h = 0; h < NUM_HEAD; h++) begin
      if (push[h]) mem[h][wptr[h]] <= push_entry[h];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned h = 0; h < NUM_HEAD; h++) begin
        wptr[h]  <= '0;
        rptr[h]  <= '0;
        count[h] <= '0;
      end
      rr_ptr <= '0;
      ovf    <= '0;
      odata  <= '0;
      omask  <= '0;
      ohead  <= '0;
      ovalid <= 1'b0;
    end else begin
      for (int unsigned h = 0; h < NUM_HEAD; h++) begin
        if (push[h]) wptr[h] <= wptr[h] + 1'b1;
        if (pop[h])  rptr[h] <= rptr[h] + 1'b1;
        count[h] <= count[h] + CW'(push[h]) - CW'(pop[h]);
        // A fresh overflow wins over a simultaneous clear.
        ovf[h] <= (req_valid[h] && full[h]) || (ovf[h] && !ovf_clr);
      end
      if (load) begin
        odata  <= mem[grant][rptr[grant]].data;
        omask  <= mem[grant][rptr[grant]].mask;
        ohead  <= grant;
        ovalid <= 1'b1;
        rr_ptr <= (grant == HW'(NUM_HEAD - 1)) ? '0 : grant + 1'b1;
      end else if (oready) begin
        ovalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/consmax_ocollect.md
CONSMAX_OCOLLECT -- requirements
Module: consmax_ocollect

Interface
REQ-001 SHALL have parameter NUM_HEAD, default 8: number of consmax heads feeding the block.
REQ-002 SHALL have parameter GBUS_DATA, default 32: per-head data width in bits.
REQ-003 SHALL have parameter GBUS_WIDTH, default 4: byte lanes per head; each lane is GBUS_DATA/GBUS_WIDTH = 8 bits.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, a power of two: entries per head FIFO.
REQ-005 SHALL have clock and reset fixed as one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port idata, input, GBUS_DATA*NUM_HEAD bits: consmax result bytes, with head h at bits [h*GBUS_DATA +: GBUS_DATA].
REQ-009 SHALL have port idata_valid, input, GBUS_WIDTH*NUM_HEAD bits: per-lane valid, with head h at bits [h*GBUS_WIDTH +: GBUS_WIDTH].
REQ-010 SHALL have port ovf_clr, input, 1 bit: clears all sticky overflow flags.
REQ-011 SHALL have port odata, output, GBUS_DATA bits: drained word.
REQ-012 SHALL have port omask, output, GBUS_WIDTH bits: lane mask of the drained word.
REQ-013 SHALL have port ohead, output, $clog2(NUM_HEAD) bits: source head index of the drained word.
REQ-014 SHALL have port ovalid, output, 1 bit: output word valid.
REQ-015 SHALL have port oready, input, 1 bit: downstream accept.
REQ-016 SHALL have port ovf, output, NUM_HEAD bits: sticky per-head overflow flags.

Function
REQ-017 SHALL push {idata head slice, lane mask} into FIFO h on a rising edge when |idata_valid[h lanes] is 1 and FIFO h is not full; lanes whose valid bit is 0 SHALL be stored as 0x00.
REQ-018 SHALL drop the push and set ovf[h] when FIFO h is full at the edge, even if the same edge pops FIFO h (full blocks push unconditionally).
REQ-019 SHALL clear ovf to 0 on an edge with ovf_clr=1; a new overflow on that same edge SHALL take priority and set its bit.
REQ-020 SHALL load the output register on an edge when (!ovalid || oready) and at least one FIFO is non-empty (count evaluated before that edge's pushes).
REQ-021 SHALL select the head by round-robin: search starts at rr_ptr and wraps modulo NUM_HEAD; after a grant to head g, rr_ptr SHALL become (g+1) mod NUM_HEAD.
REQ-022 SHALL pop the granted FIFO on the same edge that loads the output register.
REQ-023 SHALL give latency as follows: a push at edge t, into an empty system with ovalid=0, yields ovalid=1 with that word during the cycle after edge t+1.
REQ-024 SHALL hold odata, omask, ohead and ovalid stable while ovalid=1 and oready=0.
REQ-025 SHALL deassert ovalid on the edge where ovalid=1 and oready=1 and every FIFO is empty.
REQ-026 SHALL sustain one word per cycle with back-to-back loads when oready=1 continuously.
REQ-027 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH and track occupancy with a count of width $clog2(FIFO_DEPTH)+1; full is count==FIFO_DEPTH, empty is count==0.

Reset
REQ-028 SHALL, while rst=1, force ovalid=0, odata=0, omask=0, ohead=0, ovf=0, rr_ptr=0, all FIFO counts and pointers 0, asynchronously.
REQ-029 SHALL discard all FIFO contents and any held output word when rst asserts mid-operation; the first post-reset grant SHALL start its search at head 0.

Verification
REQ-030 SHALL cover single push: idata_valid=0x0000000F, head0 slice 0xA1B2C3D4, oready=1 -> two cycles later ovalid=1, odata=0xA1B2C3D4, omask=0xF, ohead=0, for one cycle.
REQ-031 SHALL cover partial mask: head3 lanes 0b0101 valid, data 0xFFFFFFFF -> odata=0x00FF00FF, omask=0x5, ohead=3.
REQ-032 SHALL cover round-robin: all 8 heads pushed once in one cycle, oready=1 -> ohead sequence 0,1,...,7 on consecutive cycles, then ovalid=0.
REQ-033 SHALL cover overflow: 5 pushes to head2 with oready=0 -> first word is loaded to output, 4 remain, ovf[2] stays 0; a 6th push -> ovf[2]=1 and the word is dropped; ovf_clr pulse -> ovf=0.
REQ-034 SHALL cover stall: ovalid=1 with oready=0 for 10 cycles -> outputs unchanged; oready=1 -> next word from the next head in round-robin order.
REQ-035 SHALL cover mid-reset: rst pulsed with 3 words queued and ovalid=1 -> ovalid=0 immediately, no stale word afterwards, ovf=0.
